// File: rtl/bpred_table_init_ctrl.sv
// bpred_table_init_ctrl: clears BTB/BHT one entry per cycle, then optionally writes host preload beats.
module bpred_table_init_ctrl #(
  parameter int ENTRIES = 256,
  parameter int ADDR_W = 8,
  parameter int BTB_W = 40,
  parameter int BHT_W = 2,
  parameter logic [BTB_W-1:0] BTB_CLR = '0,
  parameter logic [BHT_W-1:0] BHT_CLR = 2'b01,
  parameter bit AUTO_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              preload_en,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [BTB_W-1:0]  pl_btb,
  input  logic [BHT_W-1:0]  pl_bht,
  input  logic              pl_last,
  output logic              tbl_we,
  output logic [ADDR_W-1:0] btb_addr,
  output logic [ADDR_W-1:0] bht_addr,
  output logic [BTB_W-1:0]  btb_init,
  output logic [BHT_W-1:0]  bht_init,
  output logic              pc_hold,
  output logic              busy,
  output logic              init_done
);
  typedef enum logic [2:0] {IDLE, CLEAR, PRELOAD, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [BTB_W-1:0] btb_q, btb_d;
  logic [BHT_W-1:0] bht_q, bht_d;
  logic pend_q, pend_d, we_q, we_d, ready_q, ready_d, busy_q, busy_d, hold_q, hold_d, done_q, done_d;
  logic acc, last_clr, clr_wr;
  assign acc = (state_q == PRELOAD) && pl_valid && ready_q;
  assign last_clr = cnt_q == ADDR_W'(ENTRIES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    if (state_q == IDLE && (start || pend_q)) begin
      state_d = CLEAR;
      cnt_d = '0;
      pend_d = 1'b0;
    end else if (state_q == DONE && start) begin
      state_d = CLEAR;
      cnt_d = '0;
    end else if (state_q == CLEAR) begin
      state_d = last_clr ? (preload_en ? PRELOAD : DONE) : CLEAR;
      cnt_d = last_clr ? cnt_q : cnt_q + 1'b1;
    end else if (state_q == PRELOAD && acc && pl_last) begin
      state_d = FLUSH;
    end else if (state_q == FLUSH) begin
      state_d = DONE;
    end
  end
  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    clr_wr = state_d == CLEAR;
    we_d = clr_wr || acc;
    addr_d = clr_wr ? cnt_d : acc ? pl_addr : addr_q;
    btb_d = clr_wr ? BTB_CLR : acc ? pl_btb : btb_q;
    bht_d = clr_wr ? BHT_CLR : acc ? pl_bht : bht_q;
    ready_d = state_d == PRELOAD;
    busy_d = state_d inside {CLEAR, PRELOAD, FLUSH};
    hold_d = busy_d || (state_d == IDLE && pend_d);
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= AUTO_INIT;
      we_q <= 1'b0;
      addr_q <= '0;
      btb_q <= '0;
      bht_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      hold_q <= AUTO_INIT;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      we_q <= we_d;
      addr_q <= addr_d;
      btb_q <= btb_d;
      bht_q <= bht_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      hold_q <= hold_d;
      done_q <= done_d;
    end
  end
  assign pl_ready = ready_q;
  assign tbl_we = we_q;
  assign btb_addr = addr_q;
  assign bht_addr = addr_q;
  assign btb_init = btb_q;
  assign bht_init = bht_q;
  assign pc_hold = hold_q;
  assign busy = busy_q;
  assign init_done = done_q;
endmodule

// File: tb/tb_bpred_table_init_ctrl.sv
// tb_bpred_table_init_ctrl: directed checks of clear, restart, preload and abort sequencing.
module tb_bpred_table_init_ctrl;
  logic clk = 1'b0, rst, start, preload_en, pl_valid, pl_ready, pl_last;
  logic [2:0] pl_addr, btb_addr, bht_addr;
  logic [39:0] pl_btb, btb_init;
  logic [1:0] pl_bht, bht_init;
  logic tbl_we, pc_hold, busy, init_done;
  int checks = 0, errors = 0, wr_cnt = 0;
  logic [39:0] mem_btb [8];
  logic [1:0] mem_bht [8];

  bpred_table_init_ctrl #(.ENTRIES(8), .ADDR_W(3), .BTB_W(40), .BHT_W(2),
    .BTB_CLR(40'h0), .BHT_CLR(2'b01), .AUTO_INIT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .preload_en(preload_en), .pl_valid(pl_valid),
    .pl_ready(pl_ready), .pl_addr(pl_addr), .pl_btb(pl_btb), .pl_bht(pl_bht), .pl_last(pl_last),
    .tbl_we(tbl_we), .btb_addr(btb_addr), .bht_addr(bht_addr), .btb_init(btb_init),
    .bht_init(bht_init), .pc_hold(pc_hold), .busy(busy), .init_done(init_done));

  always #5 clk = ~clk;

  always @(posedge clk) if (tbl_we) begin
    mem_btb[btb_addr] <= btb_init;
    mem_bht[btb_addr] <= bht_init;
    wr_cnt <= wr_cnt + 1;
  end

  task automatic test_reset();
    rst = 1; start = 0; preload_en = 0; pl_valid = 0; pl_addr = 0; pl_btb = 0; pl_bht = 0; pl_last = 0;
    repeat (3) @(negedge clk);
    checks++; if (tbl_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", tbl_we); end
    checks++; if (busy !== 1'b0 || init_done !== 1'b0 || pl_ready !== 1'b0) begin errors++; $display("FAIL rst_flags busy=%b done=%b ready=%b exp 000", busy, init_done, pl_ready); end
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL rst_hold got %b exp 1", pc_hold); end
    rst = 0;
  endtask

  task automatic test_auto_clear();
    int w0;
    w0 = wr_cnt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (tbl_we !== 1'b1 || btb_addr !== 3'(i) || bht_addr !== 3'(i)) begin errors++; $display("FAIL auto_wr i=%0d we=%b addr=%0d/%0d exp 1 %0d", i, tbl_we, btb_addr, bht_addr, i); end
      checks++; if (btb_init !== 40'h0 || bht_init !== 2'b01) begin errors++; $display("FAIL auto_data i=%0d got %h/%b exp 0/01", i, btb_init, bht_init); end
      checks++; if (pc_hold !== 1'b1 || busy !== 1'b1 || init_done !== 1'b0) begin errors++; $display("FAIL auto_flags i=%0d hold=%b busy=%b done=%b exp 110", i, pc_hold, busy, init_done); end
    end
    @(negedge clk);
    checks++; if (tbl_we !== 1'b0 || init_done !== 1'b1 || busy !== 1'b0 || pc_hold !== 1'b0) begin errors++; $display("FAIL auto_done we=%b done=%b busy=%b hold=%b exp 0100", tbl_we, init_done, busy, pc_hold); end
    checks++; if (wr_cnt - w0 !== 8) begin errors++; $display("FAIL auto_count got %0d exp 8", wr_cnt - w0); end
  endtask

  task automatic test_ignore_pl();
    pl_valid = 1; pl_addr = 3'd6; pl_btb = 40'hFF; pl_bht = 2'b11;
    @(negedge clk);
    checks++; if (tbl_we !== 1'b0 || btb_addr !== 3'd7 || btb_init !== 40'h0) begin errors++; $display("FAIL ign_pl we=%b addr=%0d btb=%h exp 0 7 0", tbl_we, btb_addr, btb_init); end
    pl_valid = 0;
  endtask

  task automatic test_restart();
    int w0;
    w0 = wr_cnt;
    start = 1;
    @(negedge clk);
    start = 0;
    checks++; if (tbl_we !== 1'b1 || btb_addr !== 3'd0) begin errors++; $display("FAIL rs_first we=%b addr=%0d exp 1 0", tbl_we, btb_addr); end
    repeat (7) @(negedge clk);
    checks++; if (tbl_we !== 1'b1 || btb_addr !== 3'd7 || busy !== 1'b1) begin errors++; $display("FAIL rs_last we=%b addr=%0d busy=%b exp 1 7 1", tbl_we, btb_addr, busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || init_done !== 1'b1) begin errors++; $display("FAIL rs_end busy=%b done=%b exp 0 1", busy, init_done); end
    checks++; if (wr_cnt - w0 !== 8) begin errors++; $display("FAIL rs_count got %0d exp 8", wr_cnt - w0); end
  endtask

  task automatic test_start_held();
    int w0;
    w0 = wr_cnt;
    start = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (tbl_we !== 1'b1 || btb_addr !== 3'(i)) begin errors++; $display("FAIL held_wr i=%0d we=%b addr=%0d exp 1 %0d", i, tbl_we, btb_addr, i); end
    end
    start = 0;
    @(negedge clk);
    checks++; if (tbl_we !== 1'b0 || init_done !== 1'b1) begin errors++; $display("FAIL held_end we=%b done=%b exp 0 1", tbl_we, init_done); end
    checks++; if (wr_cnt - w0 !== 8) begin errors++; $display("FAIL held_count got %0d exp 8", wr_cnt - w0); end
  endtask

  task automatic test_preload();
    int w0;
    w0 = wr_cnt;
    start = 1; preload_en = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    checks++; if (btb_addr !== 3'd7 || tbl_we !== 1'b1) begin errors++; $display("FAIL pl_clrlast we=%b addr=%0d exp 1 7", tbl_we, btb_addr); end
    @(negedge clk);
    checks++; if (pl_ready !== 1'b1 || tbl_we !== 1'b0 || busy !== 1'b1 || init_done !== 1'b0) begin errors++; $display("FAIL pl_enter ready=%b we=%b busy=%b done=%b exp 1010", pl_ready, tbl_we, busy, init_done); end
    pl_valid = 1; pl_addr = 3'd3; pl_btb = 40'hA0_0000_0001; pl_bht = 2'b10; pl_last = 0;
    @(negedge clk);
    checks++; if (tbl_we !== 1'b1 || btb_addr !== 3'd3 || btb_init !== 40'hA0_0000_0001 || bht_init !== 2'b10) begin errors++; $display("FAIL pl_b1 we=%b addr=%0d btb=%h bht=%b exp 1 3 a000000001 10", tbl_we, btb_addr, btb_init, bht_init); end
    pl_valid = 0;
    @(negedge clk);
    checks++; if (tbl_we !== 1'b0 || btb_addr !== 3'd3 || pl_ready !== 1'b1) begin errors++; $display("FAIL pl_gap we=%b addr=%0d ready=%b exp 0 3 1", tbl_we, btb_addr, pl_ready); end
    pl_valid = 1; pl_addr = 3'd5; pl_btb = 40'hB0_0000_0002; pl_bht = 2'b11;
    @(negedge clk);
    checks++; if (tbl_we !== 1'b1 || btb_addr !== 3'd5 || btb_init !== 40'hB0_0000_0002) begin errors++; $display("FAIL pl_b2 we=%b addr=%0d btb=%h exp 1 5 b000000002", tbl_we, btb_addr, btb_init); end
    pl_addr = 3'd3; pl_btb = 40'hC0_0000_0003; pl_bht = 2'b00; pl_last = 1;
    @(negedge clk);
    pl_valid = 0; pl_last = 0; preload_en = 0;
    checks++; if (tbl_we !== 1'b1 || btb_addr !== 3'd3 || btb_init !== 40'hC0_0000_0003 || pl_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pl_b3 we=%b addr=%0d btb=%h ready=%b busy=%b exp 1 3 c000000003 0 1", tbl_we, btb_addr, btb_init, pl_ready, busy); end
    @(negedge clk);
    checks++; if (tbl_we !== 1'b0 || init_done !== 1'b1 || busy !== 1'b0 || pc_hold !== 1'b0) begin errors++; $display("FAIL pl_done we=%b done=%b busy=%b hold=%b exp 0100", tbl_we, init_done, busy, pc_hold); end
    checks++; if (wr_cnt - w0 !== 11) begin errors++; $display("FAIL pl_count got %0d exp 11", wr_cnt - w0); end
    checks++; if (mem_btb[3] !== 40'hC0_0000_0003 || mem_bht[3] !== 2'b00) begin errors++; $display("FAIL pl_mem3 got %h/%b exp c000000003/00", mem_btb[3], mem_bht[3]); end
    checks++; if (mem_btb[5] !== 40'hB0_0000_0002 || mem_bht[0] !== 2'b01) begin errors++; $display("FAIL pl_mem5_0 got %h/%b exp b000000002/01", mem_btb[5], mem_bht[0]); end
  endtask

  task automatic test_abort();
    int w0;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    checks++; if (btb_addr !== 3'd4 || tbl_we !== 1'b1) begin errors++; $display("FAIL ab_at4 we=%b addr=%0d exp 1 4", tbl_we, btb_addr); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++; if (tbl_we !== 1'b0 || busy !== 1'b0 || pc_hold !== 1'b1) begin errors++; $display("FAIL ab_rst we=%b busy=%b hold=%b exp 0 0 1", tbl_we, busy, pc_hold); end
    w0 = wr_cnt;
    @(negedge clk);
    checks++; if (tbl_we !== 1'b1 || btb_addr !== 3'd0) begin errors++; $display("FAIL ab_restart we=%b addr=%0d exp 1 0", tbl_we, btb_addr); end
    repeat (8) @(negedge clk);
    checks++; if (init_done !== 1'b1 || wr_cnt - w0 !== 8) begin errors++; $display("FAIL ab_done done=%b writes=%0d exp 1 8", init_done, wr_cnt - w0); end
  endtask

  initial begin
    test_reset();
    test_auto_clear();
    test_ignore_pl();
    test_restart();
    test_start_held();
    test_preload();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
